// File: rtl/text_pkg.sv
// Shared constants and cell-address payload for the text display pipeline.
package text_pkg;

  localparam int unsigned DEFAULT_MAXCOL       = 59;
  localparam int unsigned DEFAULT_MAXLIN       = 33;
  localparam int unsigned DEFAULT_BLINK_FRAMES = 16;
  localparam int unsigned FONT_W               = 8;
  localparam int unsigned FONT_H               = 8;
  localparam int unsigned CELL_W               = 6;
  localparam int unsigned ADDR_W               = 12;
  localparam int unsigned CHR_W                = 8;
  localparam int unsigned ROW_W                = 3;
  localparam int unsigned ROM_ADDR_W           = 11;
  localparam int unsigned COORD_W              = 10;
  localparam int unsigned RENDER_LATENCY       = 4;
  localparam logic [CHR_W-1:0] FIRST_PRINTABLE = 8'h20;

  typedef struct packed {
    logic [CELL_W-1:0] lin;
    logic [CELL_W-1:0] col;
  } cell_t;

endpackage

// File: rtl/text_renderer_if.sv
// Sync-generator, text-RAM, font-ROM and cursor signals around the renderer.
interface text_renderer_if;
  import text_pkg::*;

  logic [COORD_W-1:0]    i_x;
  logic [COORD_W-1:0]    i_y;
  logic                  i_de;
  logic                  i_hsync;
  logic                  i_vsync;
  logic [ADDR_W-1:0]     o_ram_addr;
  logic [CHR_W-1:0]      i_ram_data;
  logic [ROM_ADDR_W-1:0] o_rom_addr;
  logic [CHR_W-1:0]      i_rom_data;
  logic                  i_cursor_en;
  logic [ADDR_W-1:0]     i_cursor_addr;
  logic                  o_pixel;
  logic                  o_de;
  logic                  o_hsync;
  logic                  o_vsync;

  modport master (
    input  i_x, i_y, i_de, i_hsync, i_vsync, i_ram_data, i_rom_data,
           i_cursor_en, i_cursor_addr,
    output o_ram_addr, o_rom_addr, o_pixel, o_de, o_hsync, o_vsync
  );

  modport slave (
    output i_x, i_y, i_de, i_hsync, i_vsync, i_ram_data, i_rom_data,
           i_cursor_en, i_cursor_addr,
    input  o_ram_addr, o_rom_addr, o_pixel, o_de, o_hsync, o_vsync
  );

endinterface

// File: rtl/sig_delay.sv
// Fixed-depth shift register with synchronous clear.
module sig_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH*WIDTH-1:0] chain;

  if (DEPTH == 1) begin : g_single
    always_ff @(posedge clk) begin
      if (rst) chain <= '0;
      else     chain <= d;
    end
  end else begin : g_chain
    always_ff @(posedge clk) begin
      if (rst) chain <= '0;
      else     chain <= {chain[(DEPTH-1)*WIDTH-1:0], d};
    end
  end

  assign q = chain[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/text_renderer.sv
// Turns sync-generator pixel positions into text-RAM/font-ROM reads and a
// monochrome pixel, four cycles later, with an optional blinking underline cursor.
module text_renderer
  import text_pkg::*;
#(
  parameter int unsigned MAXCOL       = DEFAULT_MAXCOL,
  parameter int unsigned MAXLIN       = DEFAULT_MAXLIN,
  parameter int unsigned BLINK_FRAMES = DEFAULT_BLINK_FRAMES
) (
  input  logic            i_clk,
  input  logic            i_rst,
  text_renderer_if.master bus
);

  localparam int unsigned CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned FRONT_W = 5 + ROW_W;

  cell_t              cell_in;
  logic               outside_in;
  logic               cursor_in;
  logic [FRONT_W-1:0] front_d;
  logic [FRONT_W-1:0] front_q;
  logic               de3, hsync3, vsync3, outside3, cursor3;
  logic [ROW_W-1:0]   x3;
  logic [ROW_W-1:0]   y2;
  cell_t              ram_addr_q;
  logic               ctrl3;
  logic               pixel_q, de_q, hsync_q, vsync_q;
  logic               vsync_prev;
  logic               vsync_rise;
  logic [CNT_W-1:0]   blink_cnt;
  logic               blink_phase;

  assign cell_in    = cell_t'({bus.i_y[8:3], bus.i_x[8:3]});
  assign outside_in = bus.i_x[9] | bus.i_y[9] |
                      (cell_in.col > CELL_W'(MAXCOL)) | (cell_in.lin > CELL_W'(MAXLIN));
  // Cursor decision is taken at input sample time so enable/phase changes land on that pixel.
  assign cursor_in  = bus.i_cursor_en & blink_phase &
                      (cell_in == cell_t'(bus.i_cursor_addr)) &
                      (bus.i_y[2:0] == ROW_W'(FONT_H - 1));

  assign front_d = {bus.i_de, bus.i_hsync, bus.i_vsync, outside_in, cursor_in, bus.i_x[2:0]};

  sig_delay #(.WIDTH(FRONT_W), .DEPTH(RENDER_LATENCY - 1)) u_front (
    .clk (i_clk),
    .rst (i_rst),
    .d   (front_d),
    .q   (front_q)
  );

  assign {de3, hsync3, vsync3, outside3, cursor3, x3} = front_q;

  sig_delay #(.WIDTH(ROW_W), .DEPTH(2)) u_yrow (
    .clk (i_clk),
    .rst (i_rst),
    .d   (bus.i_y[2:0]),
    .q   (y2)
  );

  // RAM address stage and control-character flag for the ROM-data stage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ram_addr_q <= '0;
      ctrl3      <= 1'b0;
    end else begin
      ram_addr_q <= cell_in;
      ctrl3      <= (bus.i_ram_data < FIRST_PRINTABLE);
    end
  end

  assign bus.o_ram_addr = ram_addr_q;
  assign bus.o_rom_addr = {bus.i_ram_data, y2};

  // Output stage: blanking, glyph bit select and cursor override
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pixel_q <= 1'b0;
      de_q    <= 1'b0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      pixel_q <= de3 & ~outside3 & (cursor3 | (~ctrl3 & bus.i_rom_data[~x3]));
      de_q    <= de3;
      hsync_q <= hsync3;
      vsync_q <= vsync3;
    end
  end

  assign bus.o_pixel = pixel_q;
  assign bus.o_de    = de_q;
  assign bus.o_hsync = hsync_q;
  assign bus.o_vsync = vsync_q;

  // Tracks vsync through reset so a level held across release is not seen as an edge.
  always_ff @(posedge i_clk) begin
    vsync_prev <= bus.i_vsync;
  end

  assign vsync_rise = bus.i_vsync & ~vsync_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (vsync_rise) begin
      if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_text_renderer.sv
// Bench for text_renderer: constant vectors, cursor/reset sequences and
// randomized traffic against a per-pixel reference model with a 4-cycle delay line.
module tb_text_renderer;
  import text_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  text_renderer_if bus ();

  text_renderer dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [7:0] ram [4096];
  logic [7:0] rom [2048];

  always @(posedge clk) begin
    bus.i_ram_data <= ram[bus.o_ram_addr];
    bus.i_rom_data <= rom[bus.o_rom_addr];
  end

  typedef struct packed {
    logic        pix;
    logic        de;
    logic        hs;
    logic        vs;
    logic [11:0] ra;
  } exp_t;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    logic       pix;
  } vec_t;

  exp_t hist[$];
  vec_t vecs[$];
  int   k        = 0;
  int   checks   = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  logic vs_prev  = 1'b0;
  logic        cen;
  logic [11:0] ca;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0b want=%0b", name, k, act, exp);
    end
  endtask

  task automatic chk12(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h want=%0h", name, k, act, exp);
    end
  endtask

  function automatic logic phase();
    return ((edge_cnt / 16) % 2) == 1;
  endfunction

  // Reference: what the pixel at (x,y) should look like given memory and blink state.
  function automatic logic model_pix(input logic [9:0] x, input logic [9:0] y, input logic de,
                                     input logic en, input logic [11:0] cur);
    int col, lin, row;
    logic [7:0] ch, g;
    col = int'(x) / 8;
    lin = int'(y) / 8;
    row = int'(y) % 8;
    if (!de) return 1'b0;
    if (x >= 10'd512 || y >= 10'd512 || col > 59 || lin > 33) return 1'b0;
    if (en && phase() && lin == int'(cur[11:6]) && col == int'(cur[5:0]) && row == 7) return 1'b1;
    ch = ram[12'(lin * 64 + col)];
    if (ch < 8'h20) return 1'b0;
    g = rom[11'(int'(ch) * 8 + row)];
    return g[3'(7 - int'(x) % 8)];
  endfunction

  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic de,
                      input logic hs, input logic vs, input logic r, input logic pexp);
    exp_t e;
    @(negedge clk);
    if (k >= 2) begin
      e = (k >= 4) ? hist[k-4] : '0;
      chk1("pixel", bus.o_pixel, e.pix);
      chk1("de",    bus.o_de,    e.de);
      chk1("hsync", bus.o_hsync, e.hs);
      chk1("vsync", bus.o_vsync, e.vs);
      chk12("ram_addr", bus.o_ram_addr, hist[k-1].ra);
    end
    rst               = r;
    bus.i_x           = x;
    bus.i_y           = y;
    bus.i_de          = de;
    bus.i_hsync       = hs;
    bus.i_vsync       = vs;
    bus.i_cursor_en   = cen;
    bus.i_cursor_addr = ca;
    if (r) begin
      hist.push_back('0);
      for (int j = 1; j <= 3; j++) if (k - j >= 0) hist[k-j] = '0;
      edge_cnt = 0;
    end else begin
      hist.push_back('{pix: pexp, de: de, hs: hs, vs: vs, ra: {y[8:3], x[8:3]}});
      if (vs && !vs_prev) edge_cnt++;
    end
    vs_prev = vs;
    k++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      step(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic row8(input logic [9:0] y, input logic [9:0] x0, input logic [7:0] bits);
    for (int i = 0; i < 8; i++)
      step(10'(int'(x0) + i), y, 1'b1, 1'b0, 1'b0, 1'b0, bits[3'(7 - i)]);
  endtask

  initial begin
    logic [7:0] pat;
    logic [9:0] rx, ry;
    logic       rde, rvs;

    for (int i = 0; i < 4096; i++) ram[i] = 8'h41;
    for (int i = 0; i < 2048; i++) rom[i] = 8'h00;
    ram[2*64+3]    = 8'h0A;
    rom[8'h41*8+0] = 8'h3C;
    rom[8'h41*8+6] = 8'h66;
    rom[8'h41*8+7] = 8'h81;
    for (int r = 0; r < 8; r++) rom[8'h0A*8+r] = 8'hFF;

    cen = 1'b0;
    ca  = 12'd0;
    pat = 8'h3C;
    for (int i = 0; i < 8; i++) vecs.push_back('{10'(i), 10'd0, 1'b1, pat[3'(7 - i)]});
    for (int i = 0; i < 8; i++) vecs.push_back('{10'(480 + i), 10'd0, 1'b1, 1'b0});
    vecs.push_back('{10'd474, 10'd0,   1'b1, 1'b1});
    vecs.push_back('{10'd2,   10'd264, 1'b1, 1'b1});
    vecs.push_back('{10'd2,   10'd272, 1'b1, 1'b0});
    vecs.push_back('{10'd600, 10'd0,   1'b1, 1'b0});
    vecs.push_back('{10'd2,   10'd512, 1'b1, 1'b0});
    vecs.push_back('{10'd2,   10'd0,   1'b0, 1'b0});
    vecs.push_back('{10'd3,   10'd8,   1'b1, 1'b1});

    step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    foreach (vecs[i]) step(vecs[i].x, vecs[i].y, vecs[i].de, 1'b0, 1'b0, 1'b0, vecs[i].pix);

    // control character cell {2,3} is blank even though its glyph is solid
    for (int yy = 16; yy < 24; yy++)
      for (int xx = 24; xx < 32; xx++)
        step(10'(xx), 10'(yy), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    row8(10'd16, 10'd32, 8'h3C);

    cen = 1'b1;
    ca  = {6'd2, 6'd5};
    row8(10'd23, 10'd40, 8'h81);
    pulses(16);
    row8(10'd23, 10'd40, 8'hFF);
    row8(10'd22, 10'd40, 8'h66);
    pulses(16);
    row8(10'd23, 10'd40, 8'h81);
    pulses(16);
    row8(10'd23, 10'd40, 8'hFF);

    // mid-line reset, with a vsync rise hidden inside it
    for (int xx = 96; xx < 100; xx++)
      step(10'(xx), 10'd23, 1'b1, 1'b0, 1'b0, 1'b0, model_pix(10'(xx), 10'd23, 1'b1, cen, ca));
    step(10'd100, 10'd23, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int xx = 101; xx < 112; xx++)
      step(10'(xx), 10'd23, 1'b1, 1'b1, 1'b0, 1'b0, model_pix(10'(xx), 10'd23, 1'b1, cen, ca));
    row8(10'd23, 10'd40, 8'h81);
    pulses(15);
    row8(10'd23, 10'd40, 8'h81);
    pulses(1);
    row8(10'd23, 10'd40, 8'hFF);

    idle(5);
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom_range(0, 127));
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);

    for (int i = 0; i < 1000; i++) begin
      if (i % 100 == 0) ca = {6'($urandom_range(0, 33)), 6'($urandom_range(0, 59))};
      cen = ($urandom % 4) != 0;
      if ($urandom % 4 == 0) begin
        rx = 10'(int'(ca[5:0]) * 8 + int'($urandom_range(0, 7)));
        ry = 10'(int'(ca[11:6]) * 8 + 7);
      end else begin
        rx = 10'($urandom_range(0, 527));
        ry = 10'($urandom_range(0, 279));
        if ($urandom % 16 == 0) rx[9] = 1'b1;
        if ($urandom % 16 == 0) ry[9] = 1'b1;
      end
      rde = ($urandom % 10) != 0;
      rvs = ($urandom % 3) == 0;
      step(rx, ry, rde, 1'($urandom), rvs, 1'b0, model_pix(rx, ry, rde, cen, ca));
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
